// File: rtl/fadd_arb.sv
// fadd_arb: round-robin scheduler that shares one pipelined single-precision
// adder (fadd_p2, latency LAT) between NREQ requesters. At most one operation
// is issued per cycle. Each operation's requester index travels through a tag
// pipeline as deep as the adder, so the adder result is returned to the right
// requester exactly LAT cycles after issue.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset (also feeds the adder)
//   req_valid[NREQ]    per-requester request
//   req_ready[NREQ]    per-requester grant (combinational, one-hot or zero)
//   req_x1, req_x2     packed operands, requester i in bits [32i+31:32i]
//   req_sub[NREQ]      subtract request (only with FADD_ARB_SUB_EN)
//   fa_x1, fa_x2       operands to the adder, zero when nothing is issued
//   fa_y, fa_ovf       adder result
//   rsp_valid[NREQ]    one-hot or zero: result for requester i this cycle
//   rsp_tag            index of the responding requester (0 when idle)
//   rsp_y, rsp_ovf     result, passed straight through from the adder
//   busy               at least one operation in flight
//
// Build option: define FADD_ARB_SUB_EN to add req_sub. A granted request with
// req_sub=1 has the sign of x2 flipped on issue so the adder computes x1 - x2.

module fadd_arb #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  localparam int TAG_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
`ifdef FADD_ARB_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  output logic [31:0]          fa_x1,
  output logic [31:0]          fa_x2,
  input  logic [31:0]          fa_y,
  input  logic                 fa_ovf,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [31:0]          rsp_y,
  output logic                 rsp_ovf,
  output logic                 busy
);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] grant;
  logic             grant_vld;
  logic [TAG_W:0]   idx;
  logic [31:0]      x2_sel;

  logic [LAT-1:0]   vld_p;
  logic [TAG_W-1:0] tag_p [LAT];

  // Arbitration: search from ptr upward with wrap. The loop runs from the
  // farthest candidate back to ptr so the nearest valid requester wins.
  // Nothing is granted while reset is asserted.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (TAG_W+1)'(k);
      if (idx >= (TAG_W+1)'(NREQ)) idx = idx - (TAG_W+1)'(NREQ);
      if (req_valid[idx[TAG_W-1:0]]) begin
        grant     = idx[TAG_W-1:0];
        grant_vld = rstn;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant] = 1'b1;
  end

  // Issue: operands of the granted requester go straight to the adder.
  always_comb begin
    fa_x1  = '0;
    fa_x2  = '0;
    x2_sel = req_x2[32*grant +: 32];
`ifdef FADD_ARB_SUB_EN
    if (req_sub[grant]) x2_sel[31] = ~x2_sel[31];
`endif
    if (grant_vld) begin
      fa_x1 = req_x1[32*grant +: 32];
      fa_x2 = x2_sel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant == TAG_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Tag pipeline stage boundaries, aligned with the adder's internal stages.
  // Valid bits are cleared by reset so in-flight results are dropped; the tag
  // payload only matters when its valid bit is set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= grant_vld;
      for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= grant;
    for (int k = 1; k < LAT; k++) tag_p[k] <= tag_p[k-1];
  end

  // Response: last tag stage lines up with the adder output.
  always_comb begin
    rsp_valid = '0;
    rsp_tag   = '0;
    if (vld_p[LAT-1]) begin
      rsp_valid[tag_p[LAT-1]] = 1'b1;
      rsp_tag                 = tag_p[LAT-1];
    end
  end

  assign rsp_y   = fa_y;
  assign rsp_ovf = fa_ovf;
  assign busy    = |vld_p;

endmodule

// File: tb/tb_fadd_arb.sv
// Testbench for fadd_arb. A behavioural stand-in for the 2-stage adder is
// built from real arithmetic. Expected grants come from a round-robin model
// over the request mask, expected results from integer/constant arithmetic,
// and pending responses are kept in a queue keyed by their due cycle.
module tb_fadd_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_x1 = '0;
  logic [32*NREQ-1:0] req_x2 = '0;
  logic [NREQ-1:0]   req_sub = '0;
  logic [31:0]       fa_x1, fa_x2, fa_y;
  logic              fa_ovf;
  logic [NREQ-1:0]   rsp_valid;
  logic [1:0]        rsp_tag;
  logic [31:0]       rsp_y;
  logic              rsp_ovf;
  logic              busy;

  fadd_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2),
`ifdef FADD_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y), .fa_ovf(fa_ovf),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Float helpers (normal numbers and zero; overflow saturates to infinity).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [32:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 33'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, d[63], 31'd0};
    return {1'b0, d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] i2f(input int n);
    logic [32:0] t;
    t = r2f(real'(n));
    return t[31:0];
  endfunction

  // Adder stand-in: two register stages, cleared by reset.
  logic [32:0] ad_s1, ad_s2;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ad_s1 <= '0;
      ad_s2 <= '0;
    end else begin
      ad_s1 <= r2f(f2r(fa_x1) + f2r(fa_x2));
      ad_s2 <= ad_s1;
    end
  end
  assign fa_y   = ad_s2[31:0];
  assign fa_ovf = ad_s2[32];

  // Bench state
  typedef struct {
    int          due;
    int          tag;
    logic [31:0] y;
    logic        ovf;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] op1 [NREQ];
  logic [31:0] op2 [NREQ];
  logic [31:0] ey  [NREQ];
  logic        eo  [NREQ];
  logic        sb  [NREQ];
  int          m_ptr = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", name, cyc, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input logic o, input logic s);
    op1[i] = a; op2[i] = b; ey[i] = y; eo[i] = o; sb[i] = s;
  endtask

  task automatic rand_op(input int i);
    int a, b;
    logic s;
    a = int'($urandom_range(1, 1000));
    b = int'($urandom_range(1, 1000));
`ifdef FADD_ARB_SUB_EN
    s = 1'($urandom_range(0, 1));
`else
    s = 1'b0;
`endif
    set_op(i, i2f(a), i2f(b), s ? i2f(a - b) : i2f(a + b), 1'b0, s);
  endtask

  // Called just after a rising edge; drives one cycle, checks it, and returns
  // just after the next rising edge.
  task automatic run_cycle(input logic [NREQ-1:0] vmask, output int g);
    logic [NREQ-1:0] exp_ready;
    logic [31:0]     exp_x1, exp_x2;
    rsp_t            ent;
    int              idx;
    req_valid = vmask;
    for (int i = 0; i < NREQ; i++) begin
      req_x1[32*i +: 32] = op1[i];
      req_x2[32*i +: 32] = op2[i];
      req_sub[i]         = sb[i];
    end
    #4;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && vmask[idx]) g = idx;
    end
    exp_ready = '0;
    exp_x1 = '0;
    exp_x2 = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_x1 = op1[g];
      exp_x2 = op2[g];
`ifdef FADD_ARB_SUB_EN
      if (sb[g]) exp_x2[31] = ~exp_x2[31];
`endif
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("fa_x1", 64'(fa_x1), 64'(exp_x1));
    chk("fa_x2", 64'(fa_x2), 64'(exp_x2));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      ent = q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << ent.tag);
      chk("rsp_tag", 64'(rsp_tag), 64'(ent.tag));
      chk("rsp_y", 64'(rsp_y), 64'(ent.y));
      chk("rsp_ovf", 64'(rsp_ovf), 64'(ent.ovf));
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    if (g >= 0) begin
      q.push_back('{due: cyc + LAT, tag: g, y: ey[g], ovf: eo[g]});
      m_ptr = (g + 1) % NREQ;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) run_cycle('0, g);
  endtask

  // Holds reset for two cycles with requests pending, checks reset values,
  // then releases it just after a rising edge.
  task automatic reset_phase(input logic [NREQ-1:0] vmask);
    req_valid = vmask;
    rstn = 1'b0;
    #4;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_fa_x1", 64'(fa_x1), 64'd0);
    chk("rst_fa_x2", 64'(fa_x2), 64'd0);
    chk("rst_rsp_y", 64'(rsp_y), 64'd0);
    chk("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    @(posedge clk); #1;
    cyc++;
    #4;
    chk("rst_rsp_valid2", 64'(rsp_valid), 64'd0);
    chk("rst_busy2", 64'(busy), 64'd0);
    @(posedge clk); #1;
    cyc++;
    q.delete();
    m_ptr = 0;
    rstn = 1'b1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset_phase('1);

    // All four contend for 8 cycles: grants 0,1,2,3,0,1,2,3
    for (int i = 0; i < NREQ; i++)
      set_op(i, i2f(i + 1), i2f(10 * (i + 1)), i2f(11 * (i + 1)), 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) run_cycle('1, g);
    idle(LAT + 1);

    // Single add: 1.0 + 2.0 = 3.0 from requester 0
    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    run_cycle(4'b0001, g);
    idle(LAT + 1);

    // Overflow from requester 2 (leaves ptr at 3)
    set_op(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    run_cycle(4'b0100, g);
    idle(LAT + 1);

    // Pointer wrap: requesters 3 and 1 with ptr=3 -> 3, 1, 3
    set_op(1, i2f(5), i2f(6), i2f(11), 1'b0, 1'b0);
    set_op(3, i2f(7), i2f(8), i2f(15), 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(4'b1010, g);
    idle(LAT + 1);

`ifdef FADD_ARB_SUB_EN
    // Subtract: 3.0 - 1.0 from requester 1
    set_op(1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    run_cycle(4'b0010, g);
    idle(LAT + 1);
`endif

    // Single requester granted every cycle, back to back
    set_op(2, i2f(100), i2f(23), i2f(123), 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) run_cycle(4'b0100, g);
    idle(LAT + 1);

    // Randomised traffic
    for (int i = 0; i < NREQ; i++) rand_op(i);
    for (int c = 0; c < 300; c++) begin
      run_cycle(4'($urandom_range(0, 15)), g);
      if (g >= 0) rand_op(g);
    end
    idle(LAT + 1);

    // Reset mid-flight: two ops from requester 2, reset before responses
    set_op(2, i2f(9), i2f(9), i2f(18), 1'b0, 1'b0);
    run_cycle(4'b0100, g);
    run_cycle(4'b0100, g);
    reset_phase(4'b0100);
    set_op(1, i2f(2), i2f(3), i2f(5), 1'b0, 1'b0);
    set_op(3, i2f(4), i2f(4), i2f(8), 1'b0, 1'b0);
    run_cycle(4'b1010, g);
    idle(LAT + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fadd_arb.md
# fadd_arb

Round-robin scheduler that shares one 2-stage pipelined single-precision adder (`fadd_p2`) between `NREQ` requesters. It sits between the requesting units and the adder instance. It accepts at most one operation per cycle through a valid/ready handshake and tracks each in-flight operation's requester index in a tag pipeline matched to the adder latency. It returns each result to the originating requester exactly `LAT` cycles after issue.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `LAT`, default 2: adder latency in cycles, from operands driven to `y` valid. Must equal the connected adder's latency.
- `clk` in 1: clock; all state changes on its rising edge.
- `rstn` in 1: asynchronous, active-low reset. Also tied to the adder's `rstn`.
- `req_valid` in NREQ: per-requester request.
- `req_ready` out NREQ: per-requester grant; the handshake completes when valid and ready are both high.
- `req_x1` in 32*NREQ: operand 1, requester i in bits [32i+31:32i].
- `req_x2` in 32*NREQ: operand 2, same packing.
- `req_sub` in NREQ: subtract request. Only present with `FADD_ARB_SUB_EN`.
- `fa_x1`, `fa_x2` out 32: adder operands.
- `fa_y` in 32, `fa_ovf` in 1: adder result.
- `rsp_valid` out NREQ: one-hot or zero; result for requester i this cycle.
- `rsp_tag` out $clog2(NREQ): index of the responding requester.
- `rsp_y` out 32, `rsp_ovf` out 1: result, taken directly from `fa_y` and `fa_ovf`.
- `busy` out 1: at least one operation in flight.

## Operation
- **Arbitration.** Round-robin pointer `ptr` (reset 0). The grant goes to the first i with `req_valid[i]=1`, searching i = ptr, ptr+1, … modulo NREQ.
  - `req_ready` is combinational: only the granted bit is high, and it is all-zero when no requester is valid.
  - `req_ready` must not depend on `req_x*`.
- **Pointer update.** On a handshake, `ptr` becomes grant+1, wrapping from NREQ-1 to 0. With no handshake, `ptr` holds.
- **Issue.** During the handshake cycle, `fa_x1` and `fa_x2` carry the granted requester's operands combinationally. When there is no handshake they are driven to 0.
- **Tag pipeline.** A shift register of LAT entries, each holding {valid, tag}. Entry 0 loads {handshake, grant} every cycle; entry k loads entry k-1.
- **Response.** When the last entry is valid:
  - `rsp_valid[tag]=1` and `rsp_tag=tag`.
  - `rsp_y` and `rsp_ovf` carry the adder output in the same cycle.
- **No response backpressure.** Requesters must consume a result in the cycle it is presented.
- **Busy.** `busy` is the OR of all tag pipeline valid bits.
- **Requester rules.**
  - A requester holding `req_valid` high without ready must keep its operands stable.
  - A requester may deassert `req_valid` before it is granted; the block does not check for this.
- **Fairness.** With all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.

## Timing
- **Reset values.**
  - `req_ready`=0, `rsp_valid`=0, `rsp_tag`=0, `busy`=0, `fa_x1`=`fa_x2`=0.
  - `ptr`=0 and all tag entries invalid.
  - `rsp_y` and `rsp_ovf` follow the adder, which outputs 0 in reset.
- **Throughput.** One operation per cycle, with no bubbles between back-to-back grants.
- **Latency.** A handshake in cycle T produces `rsp_valid` in cycle T+LAT.
- **Simultaneous requests.** The pointer order decides; the other requesters wait with `req_ready`=0.
- **Reset mid-operation.**
  - Asserting `rstn` clears the tag pipeline asynchronously. In-flight results are dropped and never reported.
  - The first grant after reset release goes to the lowest-index valid requester.
- **Reset release.** `req_ready` may assert in the first cycle after `rstn` is released.
- **Single requester.** With only one requester valid, it is granted every cycle regardless of `ptr`.

## Configuration
- **`FADD_ARB_SUB_EN` defined.**
  - The `req_sub` port exists.
  - When the granted requester has `req_sub=1`, the issued `fa_x2` is `{~x2[31], x2[30:0]}`, so the result is x1 − x2. NaN operands are also sign-flipped.
  - A matching sub bit is not needed in the tag pipeline.
- **Not defined.** The `req_sub` port is absent and `fa_x2` is always passed through unmodified.

## Test plan
- **Single add.** Requester 0 issues 0x3F800000 + 0x40000000. Required: `req_ready[0]`=1 in the same cycle; LAT=2 cycles later `rsp_valid`=0001, `rsp_y`=0x40400000, `rsp_ovf`=0.
- **All contend.** All four requesters are valid for 8 cycles. Required grants in order 0,1,2,3,0,1,2,3. Responses arrive in the same order, 2 cycles later each, with the correct per-requester sums.
- **Overflow.** Requester 2 issues 0x7F7FFFFF + 0x7F7FFFFF. Required: `rsp_valid`=0100, `rsp_y`=0x7F800000, `rsp_ovf`=1.
- **Pointer wrap.** Requesters 3 and 1 are valid, `ptr`=3. Required: grant 3 first, then 1 (`ptr`=0 search), then `ptr`=2.
- **Reset mid-flight.** Issue two operations, then pull `rstn` low one cycle after the second. Required: `rsp_valid` never asserts for either, `busy`=0 during reset, and the next grant after release goes to the lowest-index valid requester.
- **Subtract (`FADD_ARB_SUB_EN`).** Requester 1 issues 0x40400000 with `req_sub`=1 and x2=0x3F800000. Required: `fa_x2`=0xBF800000 in the handshake cycle and `rsp_y`=0x40000000.
